spi_led_cmd_ctrl: RTL

//  Command controller between the SPI byte receiver and the three board LEDs.

---
 rtl/spi_led_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_led_cmd_ctrl.sv
// spi_led_cmd_ctrl
// Turns SPI command bytes into per-LED modes: off, on, toggle and blink.
// A command byte carries the opcode in the high nibble and the LED index in the low nibble.
// A blink command is followed by one argument byte N, which sets a half-period of N+1 ticks.
// All LED pins, o_busy and o_err are registered.
module spi_led_cmd_ctrl #(
    parameter int TICK_DIV       = 27000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_led1,
    output logic       o_led2,
    output logic       o_led3,
    output logic       o_busy,
    output logic       o_err
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    localparam logic [3:0] OP_OFF = 4'h0;
    localparam logic [3:0] OP_ON  = 4'hF;
    localparam logic [3:0] OP_TGL = 4'h8;
    localparam logic [3:0] OP_BLK = 4'hB;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ARG  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2
    } mode_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          cs_prev_r;
    logic          cs_rise_s;
    logic          byte_in_s;
    logic [3:0]    op_s;
    logic [3:0]    idx_s;
    logic [2:0]    sel_s;
    logic          op_ok_s;
    logic [2:0]    arg_sel_r;
    logic          cmd_we_s;
    logic          blink_we_s;
    logic          latch_sel_s;
    logic          err_s;
    logic [PW-1:0] presc_r;
    logic          tick_s;
    mode_t         mode_r      [3];
    mode_t         mode_nxt_s  [3];
    logic [7:0]    half_r      [3];
    logic [7:0]    half_nxt_s  [3];
    logic [8:0]    cnt_r       [3];
    logic [8:0]    cnt_nxt_s   [3];
    logic [8:0]    cnt_inc_s   [3];
    logic          phase_r     [3];
    logic          phase_nxt_s [3];
    logic [2:0]    led_nxt_s;
    logic [2:0]    led_r;
    logic          busy_r;
    logic          err_r;

    // Byte decode, chip-select edge detect and blink tick.
    always_comb begin
        op_s  = i_rx_data[7:4];
        idx_s = i_rx_data[3:0];
        case (idx_s)
            4'h1:    sel_s = 3'b001;
            4'h2:    sel_s = 3'b010;
            4'h3:    sel_s = 3'b100;
            4'hF:    sel_s = 3'b111;
            default: sel_s = 3'b000;
        endcase
        case (op_s)
            OP_OFF, OP_ON, OP_TGL, OP_BLK: op_ok_s = 1'b1;
            default:                       op_ok_s = 1'b0;
        endcase
        cs_rise_s = i_cs & ~cs_prev_r;
        // The deselect-edge cycle still belongs to the frame that is ending.
        byte_in_s = i_rx_valid & (~i_cs | cs_rise_s);
        tick_s    = (presc_r == PRESC_MAX);
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: wait for the blink argument until it arrives or the frame ends.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (byte_in_s && (sel_s != 3'b000) && (op_s == OP_BLK) && !cs_rise_s) begin
                    state_nxt_s = S_ARG;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ARG: begin
                if (byte_in_s || cs_rise_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_ARG;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM outputs: command write strobes and error request.
    always_comb begin
        cmd_we_s    = 1'b0;
        blink_we_s  = 1'b0;
        latch_sel_s = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (byte_in_s) begin
                    if ((sel_s == 3'b000) || !op_ok_s) begin
                        err_s = 1'b1;
                    end else if (op_s == OP_BLK) begin
                        // A blink command cut off by the end of its frame cannot get an argument.
                        if (cs_rise_s) begin
                            err_s = 1'b1;
                        end else begin
                            latch_sel_s = 1'b1;
                        end
                    end else begin
                        cmd_we_s = 1'b1;
                    end
                end else begin
                    err_s = 1'b0;
                end
            end
            S_ARG: begin
                if (byte_in_s) begin
                    blink_we_s = 1'b1;
                end else if (cs_rise_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            default: begin
                err_s = 1'b0;
            end
        endcase
    end

    // Context registers: previous chip select, latched LED select, prescaler, busy/err outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_prev_r <= 1'b1;
            arg_sel_r <= 3'b000;
            presc_r   <= '0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            cs_prev_r <= i_cs;
            if (latch_sel_s) begin
                arg_sel_r <= sel_s;
            end else begin
                arg_sel_r <= arg_sel_r;
            end
            if (tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRESC_ONE;
            end
            busy_r <= (state_nxt_s == S_ARG);
            err_r  <= err_s;
        end
    end

    // Per-LED next mode, blink counter and phase; pins derive from the next state.
    always_comb begin
        led_nxt_s = {3{LED_ACTIVE_LOW}};
        for (int i = 0; i < 3; i++) begin
            mode_nxt_s[i]  = mode_r[i];
            half_nxt_s[i]  = half_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            phase_nxt_s[i] = phase_r[i];
            cnt_inc_s[i]   = cnt_r[i] + 9'd1;
            if ((mode_r[i] == M_BLINK) && tick_s) begin
                // Nine-bit compare so that N=255 gives 256 ticks without wrapping.
                if (cnt_inc_s[i] == ({1'b0, half_r[i]} + 9'd1)) begin
                    cnt_nxt_s[i]   = 9'd0;
                    phase_nxt_s[i] = ~phase_r[i];
                end else begin
                    cnt_nxt_s[i] = cnt_inc_s[i];
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            if (blink_we_s && arg_sel_r[i]) begin
                mode_nxt_s[i]  = M_BLINK;
                half_nxt_s[i]  = i_rx_data;
                cnt_nxt_s[i]   = 9'd0;
                phase_nxt_s[i] = 1'b0;
            end else if (cmd_we_s && sel_s[i]) begin
                cnt_nxt_s[i]   = 9'd0;
                phase_nxt_s[i] = 1'b0;
                case (op_s)
                    OP_OFF:  mode_nxt_s[i] = M_OFF;
                    OP_ON:   mode_nxt_s[i] = M_ON;
                    OP_TGL:  mode_nxt_s[i] = (mode_r[i] == M_OFF) ? M_ON : M_OFF;
                    default: mode_nxt_s[i] = mode_r[i];
                endcase
            end else begin
                mode_nxt_s[i] = mode_nxt_s[i];
            end
            if ((mode_nxt_s[i] == M_ON) || ((mode_nxt_s[i] == M_BLINK) && !phase_nxt_s[i])) begin
                led_nxt_s[i] = ~LED_ACTIVE_LOW;
            end else begin
                led_nxt_s[i] = LED_ACTIVE_LOW;
            end
        end
    end

    // Per-LED state and registered pin drive.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 3; i++) begin
                mode_r[i]  <= M_OFF;
                half_r[i]  <= 8'd0;
                cnt_r[i]   <= 9'd0;
                phase_r[i] <= 1'b0;
            end
            led_r <= {3{LED_ACTIVE_LOW}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                mode_r[i]  <= mode_nxt_s[i];
                half_r[i]  <= half_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
                phase_r[i] <= phase_nxt_s[i];
            end
            led_r <= led_nxt_s;
        end
    end

    assign o_led1 = led_r[0];
    assign o_led2 = led_r[1];
    assign o_led3 = led_r[2];
    assign o_busy = busy_r;
    assign o_err  = err_r;

endmodule
